// File: rtl/fifo_wr_burst.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_burst
// Brief    : Burst writer for a FIFO write port, incrementing or LFSR data.
// Revision : 1.0
// ============================================================================
module fifo_wr_burst #(
  parameter int                  DATASIZE  = 8,
  parameter int                  LENSIZE   = 8,
  parameter logic [DATASIZE-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                start,
  input  logic [LENSIZE-1:0]  len,
  input  logic                mode,
  input  logic [DATASIZE-1:0] seed,
  input  logic                abort,
  input  logic                wfull,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [LENSIZE-1:0]  words_written,
  output logic [LENSIZE-1:0]  stall_cycles
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [DATASIZE-1:0] c_DATA_ONE = DATASIZE'(1);
  localparam logic [LENSIZE-1:0]  c_LEN_ONE  = LENSIZE'(1);

  logic [1:0]          r_state, w_state_nxt;
  logic [LENSIZE-1:0]  r_len, w_len_nxt;
  logic                r_mode, w_mode_nxt;
  logic                r_winc, w_winc_nxt;
  logic [DATASIZE-1:0] r_wdata, w_wdata_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_aborted, w_aborted_nxt;
  logic [LENSIZE-1:0]  r_words, w_words_nxt;
  logic [LENSIZE-1:0]  r_stalls, w_stalls_nxt;

  logic                w_accept;
  logic [LENSIZE-1:0]  w_words_inc;
  logic [DATASIZE-1:0] w_seed_fix;
  logic [DATASIZE-1:0] w_pat_next;

  assign w_accept    = r_winc & ~wfull;
  assign w_words_inc = r_words + c_LEN_ONE;
  // An all-zero LFSR state would lock up, so a zero seed starts at 1 instead.
  assign w_seed_fix  = (mode && (seed == '0)) ? c_DATA_ONE : seed;
  assign w_pat_next  = r_mode ? {r_wdata[DATASIZE-2:0], ^(r_wdata & LFSR_TAPS)}
                              : r_wdata + c_DATA_ONE;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state   <= c_IDLE;
      r_len     <= '0;
      r_mode    <= 1'b0;
      r_winc    <= 1'b0;
      r_wdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_words   <= '0;
      r_stalls  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_mode    <= w_mode_nxt;
      r_winc    <= w_winc_nxt;
      r_wdata   <= w_wdata_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      r_words   <= w_words_nxt;
      r_stalls  <= w_stalls_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_state_nxt = (len != '0) ? c_RUN : c_DONE;
        end
      end
      c_RUN: begin
        if (abort || (w_accept && (w_words_inc == r_len))) begin
          w_state_nxt = c_DONE;
        end
      end
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Next values of the registered outputs; winc/busy/done follow the next state.
  always_comb begin
    w_len_nxt     = r_len;
    w_mode_nxt    = r_mode;
    w_wdata_nxt   = r_wdata;
    w_aborted_nxt = r_aborted;
    w_words_nxt   = r_words;
    w_stalls_nxt  = r_stalls;
    w_winc_nxt    = (w_state_nxt == c_RUN);
    w_busy_nxt    = (w_state_nxt == c_RUN);
    w_done_nxt    = (w_state_nxt == c_DONE);
    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_len_nxt     = len;
          w_mode_nxt    = mode;
          w_aborted_nxt = 1'b0;
          w_words_nxt   = '0;
          w_stalls_nxt  = '0;
          if (len != '0) begin
            w_wdata_nxt = w_seed_fix;
          end
        end
      end
      c_RUN: begin
        if (w_accept) begin
          w_words_nxt = w_words_inc;
          w_wdata_nxt = w_pat_next;
        end else if (r_winc && wfull && (r_stalls != '1)) begin
          w_stalls_nxt = r_stalls + c_LEN_ONE;
        end
        if (abort) begin
          w_aborted_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign winc          = r_winc;
  assign wdata         = r_wdata;
  assign busy          = r_busy;
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign words_written = r_words;
  assign stall_cycles  = r_stalls;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_burst.sv
`default_nettype none
// Bench for fifo_wr_burst: burst vector table, data scoreboard, reset sequence.
module tb_fifo_wr_burst;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       start;
  logic [7:0] len;
  logic       mode;
  logic [7:0] seed;
  logic       abort;
  logic       wfull;
  logic       winc;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] words_written;
  logic [7:0] stall_cycles;

  fifo_wr_burst #(.DATASIZE(8), .LENSIZE(8), .LFSR_TAPS(8'hB8)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .start(start), .len(len), .mode(mode),
    .seed(seed), .abort(abort), .wfull(wfull), .winc(winc), .wdata(wdata),
    .busy(busy), .done(done), .aborted(aborted),
    .words_written(words_written), .stall_cycles(stall_cycles)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [7:0] len;
    logic       mode;
    logic [7:0] seed;
    int         stall_at;
    int         stall_n;
    int         abort_at;
    bit         spam_start;
    bit         abort_on_start;
    int         exp_words;
    int         exp_stalls;
    bit         exp_aborted;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] exp_q[$];
  int         n_pass  = 0;
  int         n_total = 0;
  int         n_acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] pat_next(input logic [7:0] d, input logic m);
    return m ? {d[6:0], ^(d & 8'hB8)} : d + 8'd1;
  endfunction

  // Called with the clock low; the coming rising edge accepts if winc && !wfull.
  task automatic tick();
    logic [7:0] e;
    if (winc && !wfull) begin
      if (exp_q.size() == 0) begin
        chk("extra_write", {24'd0, wdata}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wdata", {24'd0, wdata}, {24'd0, e});
      end
      n_acc++;
    end
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] w;
    int         stalls_left;
    bit         timeout;
    w = (v.mode && v.seed == 8'd0) ? 8'h01 : v.seed;
    for (int i = 0; i < v.exp_words; i++) begin
      exp_q.push_back(w);
      w = pat_next(w, v.mode);
    end
    n_acc = 0;
    stalls_left = v.stall_n;
    start = 1'b1; len = v.len; mode = v.mode; seed = v.seed;
    wfull = 1'b0; abort = v.abort_on_start;
    tick();
    start = 1'b0; abort = 1'b0;
    if (v.len != 8'd0) begin
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("winc_after_start", {31'd0, winc}, 32'd1);
    end else begin
      chk("winc_len0", {31'd0, winc}, 32'd0);
    end
    timeout = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      wfull = (n_acc == v.stall_at) && (stalls_left > 0);
      if (wfull) begin
        stalls_left--;
        if (exp_q.size() > 0) chk("wdata_hold", {24'd0, wdata}, {24'd0, exp_q[0]});
      end
      abort = (v.abort_at != 0) && (n_acc == v.abort_at - 1) && !wfull;
      if (v.spam_start) begin
        start = 1'b1; len = 8'd1; mode = 1'b1; seed = 8'h55;
      end
      tick();
    end
    start = 1'b0; wfull = 1'b0; abort = 1'b0;
    if (timeout) chk("done_timeout", 32'd0, 32'd1);
    chk("words_written", {24'd0, words_written}, v.exp_words);
    chk("stall_cycles", {24'd0, stall_cycles}, v.exp_stalls);
    chk("aborted", {31'd0, aborted}, {31'd0, v.exp_aborted});
    chk("winc_at_done", {31'd0, winc}, 32'd0);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("aborted_hold", {31'd0, aborted}, {31'd0, v.exp_aborted});
    chk("words_hold", {24'd0, words_written}, v.exp_words);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          len    mode  seed   st_at st_n ab_at spam abst words stalls ab
    vecs[0] = '{8'd4,  1'b0, 8'hFE, 0,    0,   0,    0,   0,   4,    0,     0};
    vecs[1] = '{8'd3,  1'b0, 8'h10, 0,    5,   0,    0,   0,   3,    5,     0};
    vecs[2] = '{8'd3,  1'b1, 8'h00, 0,    0,   0,    0,   0,   3,    0,     0};
    vecs[3] = '{8'd10, 1'b0, 8'h20, 0,    0,   3,    0,   0,   3,    0,     1};
    vecs[4] = '{8'd0,  1'b0, 8'h44, 0,    0,   0,    0,   0,   0,    0,     0};
    vecs[5] = '{8'd5,  1'b1, 8'hA5, 0,    0,   0,    1,   0,   5,    0,     0};
    vecs[6] = '{8'd2,  1'b0, 8'h7F, 0,    0,   0,    0,   1,   2,    0,     0};
    vecs[7] = '{8'd6,  1'b1, 8'h3C, 2,    3,   5,    0,   0,   5,    3,     1};
    vecs[8] = '{8'd1,  1'b0, 8'hFF, 0,    0,   0,    0,   0,   1,    0,     0};
    vecs[9] = '{8'd2,  1'b0, 8'h90, 1,    300, 0,    0,   0,   2,    255,   0};

    wrst_n = 1'b0; start = 1'b0; len = 8'd0; mode = 1'b0; seed = 8'd0;
    abort = 1'b0; wfull = 1'b0; n_acc = 0;
    @(negedge wclk); @(negedge wclk);
    chk("rst_winc", {31'd0, winc}, 32'd0);
    chk("rst_wdata", {24'd0, wdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_counters", {16'd0, words_written, stall_cycles}, 32'd0);
    wrst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset in the middle of a burst after two accepted words.
    start = 1'b1; len = 8'd6; mode = 1'b0; seed = 8'h30;
    for (int i = 0; i < 6; i++) exp_q.push_back(8'h30 + 8'(i));
    n_acc = 0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && n_acc < 2; c++) tick();
    chk("pre_rst_words", {24'd0, words_written}, 32'd2);
    wrst_n = 1'b0;
    #1;
    chk("midrst_winc", {31'd0, winc}, 32'd0);
    chk("midrst_wdata", {24'd0, wdata}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_flags", {30'd0, done, aborted}, 32'd0);
    chk("midrst_counters", {16'd0, words_written, stall_cycles}, 32'd0);
    exp_q.delete();
    @(posedge wclk); @(negedge wclk);
    chk("rst_no_done", {31'd0, done}, 32'd0);
    wrst_n = 1'b1;
    tick();
    chk("post_rst_idle", {30'd0, busy, done}, 32'd0);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
